cla_limb_sequencer: RTL and testbench
=====================================

CLA_LIMB_SEQUENCER -- requirements
Module: cla_limb_sequencer

Interface
REQ-001 SHALL have parameter LIMB_W, default 64, limb width; fixed to the CLA_64bit width, any other value unsupported.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  synchronous abort of the current transaction.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1  limb input handshake.
REQ-006 SHALL have ports in_a, in_b  input  64 each  operand limbs, least-significant limb first.
REQ-007 SHALL have ports in_last input 1 (final limb), op_sub input 1, cin_ext input 1 (op_sub and cin_ext sampled on first limb only).
REQ-008 SHALL have ports out_valid output 1 / out_ready input 1  result handshake.
REQ-009 SHALL have ports out_sum output 64, out_idx output 8 (limb index), out_last output 1.
REQ-010 SHALL have ports out_cout output 1 and out_ovf output 1, meaningful only when out_last=1.

Function
REQ-011 SHALL implement FSM states FIRST (next limb starts a transaction) and MID (inside a transaction).
REQ-012 SHALL accept a limb when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-013 SHALL present the result of an accepted limb on the next clock edge: latency 1, throughput 1 limb/cycle.
REQ-014 In FIRST: CLA B = op_sub ? ~in_b : in_b; Cin = op_sub ? 1 : cin_ext; op_sub latched into op_sub_q.
REQ-015 In MID: CLA B = op_sub_q ? ~in_b : in_b; Cin = carry_q.
REQ-016 On each accept: carry_q <= CLA Cout; out_idx <= 0 in FIRST, previous out_idx+1 in MID (8-bit wrap, transaction length unbounded).
REQ-017 Transition FIRST->MID on accept with in_last=0; MID->FIRST on accept with in_last=1; FIRST stays FIRST on single-limb (in_last=1) accept.
REQ-018 out_cout SHALL equal final CLA Cout (for subtract: 1 = no borrow).
REQ-019 out_ovf SHALL equal (in_a[63] == B'[63]) && (sum[63] != in_a[63]) of the last limb, B' the possibly inverted operand.
REQ-020 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-021 flush SHALL force FIRST, clear out_valid and carry_q next edge; flush wins over a simultaneous accept (limb dropped, in_ready ignored).
REQ-022 in_valid while out_valid && !out_ready SHALL not be accepted; no limb lost or duplicated.

Reset
REQ-023 rst_n low SHALL immediately force state FIRST, out_valid=0, carry_q=0, op_sub_q=0, out_sum=0, out_idx=0, out_last=0, out_cout=0, out_ovf=0.
REQ-024 Reset mid-transaction SHALL discard it; first accept after release is treated as a first limb.

Structure
REQ-025 Shared package SHALL hold LIMB_W constant, IDX_W=8, and the FSM state encoding (FIRST=0, MID=1).
REQ-026 SHALL instantiate exactly one CLA_64bit (ports Sum, Cout, A, B, Cin) as sub-module; no other adder in the datapath.

Verification
REQ-027 Single limb add A=FFFF_FFFF_FFFF_FFFF, B=1, cin_ext=0, last -> sum=0, cout=1, ovf=0, idx=0, last=1.
REQ-028 Two-limb add {0,FFFF_FFFF_FFFF_FFFF}+{0,1} -> limb0 sum=0 idx=0, limb1 sum=1 idx=1 last=1, cout=0.
REQ-029 Two-limb sub {1,0}-{0,1} (op_sub=1) -> limb0 sum=FFFF_FFFF_FFFF_FFFF, limb1 sum=0, cout=1.
REQ-030 Single add A=7FFF_FFFF_FFFF_FFFF, B=1 -> sum=8000_0000_0000_0000, ovf=1, cout=0.
REQ-031 out_ready low 3 cycles during 4-limb stream -> in_ready low, outputs stable, all 4 results delivered in order.
REQ-032 flush (and separately rst_n) after limb0 of 3, then limb A=5,B=0,cin_ext=1,last -> sum=6, idx=0, no stale outputs.

Source files
------------

// File: rtl/cla_limb_sequencer_pkg.sv
// Shared constants and FSM encoding for the multi-limb CLA sequencer.
package cla_limb_sequencer_pkg;

  localparam int LIMB_W = 64;
  localparam int IDX_W  = 8;

  typedef enum logic {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } state_e;

endpackage

// File: rtl/cla_limb_sequencer_cla.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate.
module CLA_64bit
  import cla_limb_sequencer_pkg::*;
(
  input  logic [LIMB_W-1:0] A,
  input  logic [LIMB_W-1:0] B,
  input  logic              Cin,
  output logic [LIMB_W-1:0] Sum,
  output logic              Cout
);

  localparam int NG = LIMB_W / 4;

  logic [LIMB_W-1:0] g_s;
  logic [LIMB_W-1:0] p_s;
  logic [LIMB_W-1:0] c_s;
  logic [NG-1:0]     gg_s;
  logic [NG-1:0]     gp_s;
  logic [NG:0]       gc_s;

  // Bit and group generate/propagate, group carries, then in-group lookahead carries
  always_comb begin
    g_s  = A & B;
    p_s  = A ^ B;
    c_s  = '0;
    gg_s = '0;
    gp_s = '0;
    gc_s = '0;
    gc_s[0] = Cin;
    for (int j = 0; j < NG; j++) begin
      gg_s[j] = g_s[4*j+3]
              | (p_s[4*j+3] & g_s[4*j+2])
              | (p_s[4*j+3] & p_s[4*j+2] & g_s[4*j+1])
              | (p_s[4*j+3] & p_s[4*j+2] & p_s[4*j+1] & g_s[4*j]);
      gp_s[j]   = &p_s[4*j +: 4];
      gc_s[j+1] = gg_s[j] | (gp_s[j] & gc_s[j]);
      c_s[4*j]   = gc_s[j];
      c_s[4*j+1] = g_s[4*j] | (p_s[4*j] & gc_s[j]);
      c_s[4*j+2] = g_s[4*j+1] | (p_s[4*j+1] & g_s[4*j])
                 | (p_s[4*j+1] & p_s[4*j] & gc_s[j]);
      c_s[4*j+3] = g_s[4*j+2] | (p_s[4*j+2] & g_s[4*j+1])
                 | (p_s[4*j+2] & p_s[4*j+1] & g_s[4*j])
                 | (p_s[4*j+2] & p_s[4*j+1] & p_s[4*j] & gc_s[j]);
    end
    Sum  = p_s ^ c_s;
    Cout = gc_s[NG];
  end

endmodule

// File: rtl/cla_limb_sequencer.sv
// Streams operand limbs (LS limb first) through one CLA, chaining carry across limbs
// of a transaction; add or subtract chosen on the first limb.
module cla_limb_sequencer
  import cla_limb_sequencer_pkg::*;
#(
  parameter int LIMB_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] in_a,
  input  logic [LIMB_W-1:0] in_b,
  input  logic              in_last,
  input  logic              op_sub,
  input  logic              cin_ext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_sum,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_cout,
  output logic              out_ovf
);

  state_e            state_q, state_d;
  logic              op_sub_q, op_sub_d;
  logic              carry_q, carry_d;
  logic              out_valid_q, out_valid_d;
  logic [LIMB_W-1:0] out_sum_q, out_sum_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              out_cout_q, out_cout_d;
  logic              out_ovf_q, out_ovf_d;

  logic              first_s;
  logic              sub_eff_s;
  logic              accept_s;
  logic [LIMB_W-1:0] cla_b_s;
  logic              cla_cin_s;
  logic [LIMB_W-1:0] cla_sum_s;
  logic              cla_cout_s;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign first_s   = (state_q == ST_FIRST);
  assign sub_eff_s = first_s ? op_sub : op_sub_q;
  assign cla_b_s   = sub_eff_s ? ~in_b : in_b;
  // Subtraction is A + ~B + 1 on the first limb; later limbs take the chained carry.
  assign cla_cin_s = first_s ? (op_sub | cin_ext) : carry_q;

  CLA_64bit u_cla (
    .A   (in_a),
    .B   (cla_b_s),
    .Cin (cla_cin_s),
    .Sum (cla_sum_s),
    .Cout(cla_cout_s)
  );

  // Next-state: flush beats accept, accept beats output drain
  always_comb begin
    state_d     = state_q;
    op_sub_d    = op_sub_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    out_cout_d  = out_cout_q;
    out_ovf_d   = out_ovf_q;
    if (flush) begin
      state_d     = ST_FIRST;
      out_valid_d = 1'b0;
      carry_d     = 1'b0;
    end else if (accept_s) begin
      out_valid_d = 1'b1;
      out_sum_d   = cla_sum_s;
      out_last_d  = in_last;
      out_cout_d  = cla_cout_s;
      out_ovf_d   = (in_a[LIMB_W-1] == cla_b_s[LIMB_W-1]) &&
                    (cla_sum_s[LIMB_W-1] != in_a[LIMB_W-1]);
      carry_d     = cla_cout_s;
      state_d     = in_last ? ST_FIRST : ST_MID;
      if (first_s) begin
        op_sub_d  = op_sub;
        out_idx_d = '0;
      end else begin
        out_idx_d = out_idx_q + IDX_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FIRST;
      op_sub_q    <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      out_cout_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_sub_q    <= op_sub_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_cout_q  <= out_cout_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_cla_limb_sequencer.sv
// Directed and randomized bench for cla_limb_sequencer; results are predicted from
// multi-limb integer add/subtract arithmetic and matched in order through a queue.
module tb_cla_limb_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_last;
  logic        op_sub;
  logic        cin_ext;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic [7:0]  out_idx;
  logic        out_last;
  logic        out_cout;
  logic        out_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  typedef struct {
    logic [63:0] sum;
    logic [7:0]  idx;
    logic        last;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  bit   m_mid   = 1'b0;
  bit   m_sub   = 1'b0;
  bit   m_carry = 1'b0;
  int   m_idx   = 0;

  cla_limb_sequencer #(.LIMB_W(64)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .op_sub   (op_sub),
    .cin_ext  (cin_ext),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_idx  (out_idx),
    .out_last (out_last),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: one limb of a multi-limb integer A+B+cin or A-B with borrow chaining.
  task automatic model_accept();
    exp_t        e;
    logic        c;
    logic [64:0] full;
    if (!m_mid) begin
      m_sub = op_sub;
      c     = op_sub ? 1'b1 : cin_ext;
      m_idx = 0;
    end else begin
      c     = m_carry;
      m_idx = (m_idx + 1) % 256;
    end
    if (m_sub) begin
      full  = 65'h1_0000_0000_0000_0000 + {1'b0, in_a} - {1'b0, in_b} - {64'd0, ~c};
      e.ovf = (in_a[63] != in_b[63]) && (full[63] != in_a[63]);
    end else begin
      full  = {1'b0, in_a} + {1'b0, in_b} + {64'd0, c};
      e.ovf = (in_a[63] == in_b[63]) && (full[63] != in_a[63]);
    end
    e.sum   = full[63:0];
    e.cout  = full[64];
    e.idx   = 8'(m_idx);
    e.last  = in_last;
    m_carry = full[64];
    m_mid   = !in_last;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the presented output to the model every cycle, then apply handshakes
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_mid = 1'b0;
      end else begin
        chk_eq("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
        if (out_valid && exp_q.size() != 0) begin
          e = exp_q[0];
          chk_eq("out_sum", out_sum, e.sum);
          chk_eq("out_idx", {56'd0, out_idx}, {56'd0, e.idx});
          chk_eq("out_last", {63'd0, out_last}, {63'd0, e.last});
          if (e.last) begin
            chk_eq("out_cout", {63'd0, out_cout}, {63'd0, e.cout});
            chk_eq("out_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
          end
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
        if (flush) begin
          exp_q.delete();
          m_mid   = 1'b0;
          m_carry = 1'b0;
        end else if (in_valid && in_ready) begin
          model_accept();
        end
      end
    end
  end

  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic last, input logic sub, input logic cin);
    bit acc = 1'b0;
    in_a = a; in_b = b; in_last = last; op_sub = sub; cin_ext = cin;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready && !flush;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk_eq("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic expect_out(input string tag, input logic [63:0] sum, input logic [7:0] idx,
                            input logic last);
    chk_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk_eq({tag, "_sum"}, out_sum, sum);
    chk_eq({tag, "_idx"}, {56'd0, out_idx}, {56'd0, idx});
    chk_eq({tag, "_last"}, {63'd0, out_last}, {63'd0, last});
  endtask

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 5))
      0:       return 64'h0;
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      2:       return 64'h7FFF_FFFF_FFFF_FFFF;
      3:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    bit acc;
    int rem;
    int base;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = 64'd0; in_b = 64'd0; in_last = 1'b0; op_sub = 1'b0; cin_ext = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    chk_eq("rst_sum", out_sum, 64'd0);
    chk_eq("rst_idx", {56'd0, out_idx}, 64'd0);
    chk_eq("rst_flags", {61'd0, out_last, out_cout, out_ovf}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-limb add wrapping to zero
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 1'b0);
    expect_out("s_wrap", 64'd0, 8'd0, 1'b1);
    chk_eq("s_wrap_cout", {63'd0, out_cout}, 64'd1);
    chk_eq("s_wrap_ovf", {63'd0, out_ovf}, 64'd0);

    // Two-limb add with carry into limb 1
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0);
    expect_out("add2_l0", 64'd0, 8'd0, 1'b0);
    send(64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
    expect_out("add2_l1", 64'd1, 8'd1, 1'b1);
    chk_eq("add2_cout", {63'd0, out_cout}, 64'd0);

    // Two-limb subtract {1,0}-{0,1}; op_sub/cin_ext on limb 1 must be ignored
    send(64'd0, 64'd1, 1'b0, 1'b1, 1'b0);
    expect_out("sub2_l0", 64'hFFFF_FFFF_FFFF_FFFF, 8'd0, 1'b0);
    send(64'd1, 64'd0, 1'b1, 1'b0, 1'b1);
    expect_out("sub2_l1", 64'd0, 8'd1, 1'b1);
    chk_eq("sub2_cout", {63'd0, out_cout}, 64'd1);

    // Signed overflow
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 1'b0);
    expect_out("ovf", 64'h8000_0000_0000_0000, 8'd0, 1'b1);
    chk_eq("ovf_flag", {63'd0, out_ovf}, 64'd1);
    chk_eq("ovf_cout", {63'd0, out_cout}, 64'd0);

    // Backpressure for 3 cycles in a 4-limb stream
    @(posedge clk); #1;
    base = n_out;
    send(64'd10, 64'd1, 1'b0, 1'b0, 1'b0);
    send(64'd20, 64'd2, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    fork
      begin
        repeat (3) begin
          @(negedge clk);
          chk_eq("bp_in_ready", {63'd0, in_ready}, 64'd0);
          chk_eq("bp_hold_sum", out_sum, 64'd22);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join_none
    send(64'd30, 64'd3, 1'b0, 1'b0, 1'b0);
    send(64'd40, 64'd4, 1'b1, 1'b0, 1'b0);
    expect_out("bp_l3", 64'd44, 8'd3, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk_eq("bp_delivered", 64'(n_out - base), 64'd4);

    // Flush after limb0 of 3, with a simultaneous limb offered (must be dropped)
    send(64'd100, 64'd200, 1'b0, 1'b1, 1'b0);
    in_a = 64'd7; in_b = 64'd7; in_last = 1'b0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk_eq("flush_valid", {63'd0, out_valid}, 64'd0);
    send(64'd5, 64'd0, 1'b1, 1'b0, 1'b1);
    expect_out("flush_new", 64'd6, 8'd0, 1'b1);

    // Reset after limb0 of 3
    send(64'd100, 64'd200, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_eq("mrst_valid", {63'd0, out_valid}, 64'd0);
    chk_eq("mrst_sum", out_sum, 64'd0);
    chk_eq("mrst_idx_flags", {53'd0, out_idx, out_last, out_cout, out_ovf}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(64'd5, 64'd0, 1'b1, 1'b0, 1'b1);
    expect_out("rst_new", 64'd6, 8'd0, 1'b1);

    // Long transaction: index wraps past 255
    for (int i = 0; i < 260; i++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, (i == 259), 1'b1, 1'b0);
    end
    chk_eq("wrap_idx", {56'd0, out_idx}, 64'd3);

    // Randomized traffic with backpressure, gaps and occasional flush
    rem = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready && !flush;
      @(posedge clk);
      #1;
      if (acc) rem--;
      flush     = ($urandom_range(0, 49) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        if (rem <= 0) rem = $urandom_range(1, 6);
        in_valid = ($urandom_range(0, 4) != 0);
        in_a     = pick64();
        in_b     = pick64();
        in_last  = (rem == 1);
        op_sub   = 1'($urandom_range(0, 1));
        cin_ext  = 1'($urandom_range(0, 1));
      end
    end

    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_eq("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
